tofpet_readout_arbiter: RTL and testbench
=========================================

TOFPET_READOUT_ARBITER -- requirements
Module: tofpet_readout_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32, data word width of each TofPet data FIFO.
REQ-002 SHALL have parameter NCH, default 6, number of TofPet data FIFOs, legal range 2..8.
REQ-003 SHALL have port CK, input, 1, single clock, 100 MHz, all state on rising edge.
REQ-004 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port FIFO_DATA, input, NCH*DW, show-ahead FIFO outputs, channel i at bits [i*DW +: DW].
REQ-006 SHALL have port FIFO_EMPTY, input, NCH, per-channel empty flags.
REQ-007 SHALL have port FIFO_READ, output, NCH, per-channel pop strobes, one word per cycle high.
REQ-008 SHALL have port CH_ENABLE, input, NCH, channel participation mask.
REQ-009 SHALL have port BURST_LEN, input, 8, maximum words per grant, 0 = unlimited.
REQ-010 SHALL have port OUT_DATA, output, DW, merged output word.
REQ-011 SHALL have port OUT_CH, output, 3, source channel of OUT_DATA.
REQ-012 SHALL have port OUT_VALID, output, 1, OUT_DATA/OUT_CH valid.
REQ-013 SHALL have port OUT_READY, input, 1, downstream accepts word when OUT_VALID & OUT_READY.
REQ-014 SHALL have port BUSY, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port GRANT_CH, output, 3, currently or last granted channel.

Function
REQ-016 SHALL implement states IDLE, HDR, XFER.
REQ-017 IDLE: request vector = ~FIFO_EMPTY & CH_ENABLE; if nonzero, register grant = first set bit searching from LAST+1 upward with wrap, go HDR (macro on) or XFER (macro off).
REQ-018 Output stage SHALL be a one-deep register; "slot free" = ~OUT_VALID | OUT_READY.
REQ-019 XFER: FIFO_READ[grant] SHALL be combinational = ~FIFO_EMPTY[grant] & CH_ENABLE[grant] & slot free & (BURST_LEN==0 | wcnt<BURST_LEN); all other FIFO_READ bits 0.
REQ-020 On an edge where FIFO_READ[grant]=1, OUT_DATA <= FIFO_DATA[grant], OUT_CH <= grant, OUT_VALID <= 1, wcnt <= wcnt+1; zero added latency, one word per cycle sustained.
REQ-021 OUT_VALID SHALL clear on OUT_READY when no new word loads that edge; OUT_DATA SHALL hold while OUT_VALID & ~OUT_READY.
REQ-022 XFER SHALL exit to IDLE, setting LAST <= grant and wcnt <= 0, when FIFO_EMPTY[grant], CH_ENABLE[grant]=0, or wcnt reaches nonzero BURST_LEN, evaluated after that edge's pop.
REQ-023 wcnt SHALL be 8 bits and not wrap; BURST_LEN=0 holds grant until empty or disabled.
REQ-024 IDLE->grant->XFER SHALL cost one cycle of bubble per grant; no FIFO_READ in IDLE.
REQ-025 Only-one-requester case SHALL re-grant the same channel after the IDLE bubble.
REQ-026 FIFO_READ SHALL never assert for an empty or disabled channel.
REQ-027 BURST_LEN changes SHALL take effect on the next comparison; mid-burst change below wcnt ends the burst.

Reset
REQ-028 RESET SHALL force IDLE, OUT_VALID=0, OUT_DATA=0, OUT_CH=0, wcnt=0, GRANT_CH=0, LAST=NCH-1, so channel 0 wins first, and FIFO_READ=0 asynchronously.
REQ-029 Reset mid-burst SHALL discard the held output word; no pop occurs during reset.

Configuration
REQ-030 With TOFPET_ARB_HEADER_EN defined, HDR SHALL load one header word {16'hC0DE, 13'b0, grant[2:0]} with OUT_CH=grant when slot free, then enter XFER; wcnt excludes the header.
REQ-031 Without TOFPET_ARB_HEADER_EN, HDR SHALL not exist and IDLE goes directly to XFER.

Verification
REQ-032 Ch0 holds 3 words, others empty, BURST_LEN=0, OUT_READY=1 -> 3 consecutive OUT_VALID words, OUT_CH=0, READ[0] high 3 cycles, back to IDLE.
REQ-033 Ch1 and ch4 each hold 10 words, BURST_LEN=4 -> order 4xch1, 4xch4, 4xch1, 4xch4, 2xch1, 2xch4.
REQ-034 OUT_READY held low 5 cycles mid-burst -> OUT_DATA stable, no FIFO_READ, no word lost or duplicated.
REQ-035 CH_ENABLE[2] cleared during ch2 burst -> no further READ[2] from next cycle, grant moves on.
REQ-036 RESET pulsed mid-burst -> OUT_VALID=0 immediately, next grant goes to lowest nonempty enabled channel.
REQ-037 Macro on, ch3 holds 2 words -> output 32'hC0DE0003 then 2 data words, all OUT_CH=3.

Source files
------------

// File: rtl/tofpet_readout_arbiter.sv
// Round-robin merger of NCH show-ahead TofPet data FIFOs into one registered output stream.
// Optional per-grant header word when TOFPET_ARB_HEADER_EN is defined (header mode assumes DW >= 32).
module tofpet_readout_arbiter #(
    parameter int DW  = 32,
    parameter int NCH = 6
) (
    input  logic              CK,
    input  logic              RESET,
    input  logic [NCH*DW-1:0] FIFO_DATA,
    input  logic [NCH-1:0]    FIFO_EMPTY,
    output logic [NCH-1:0]    FIFO_READ,
    input  logic [NCH-1:0]    CH_ENABLE,
    input  logic [7:0]        BURST_LEN,
    output logic [DW-1:0]     OUT_DATA,
    output logic [2:0]        OUT_CH,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              BUSY,
    output logic [2:0]        GRANT_CH
);

`ifdef TOFPET_ARB_HEADER_EN
    typedef enum logic [1:0] {IDLE, HDR, XFER} state_t;
`else
    typedef enum logic [1:0] {IDLE, XFER} state_t;
`endif

    state_t          state_q, state_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      last_q, last_d;
    logic [7:0]      wcnt_q, wcnt_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [2:0]      out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;

    logic [NCH-1:0]  req;
    logic            slot_free;
    logic            burst_ok;
    logic            pop;
    logic [7:0]      wcnt_n;

    // Search upward from the channel after the last grant, wrapping at NCH.
    function automatic logic [2:0] rr_pick(input logic [2:0] last, input logic [NCH-1:0] r);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            idx = int'(last) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && r[idx]) begin
                pick  = 3'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef TOFPET_ARB_HEADER_EN
    function automatic logic [DW-1:0] hdr_word(input logic [2:0] g);
        logic [31:0] w;
        w = {16'hC0DE, 13'b0, g};
        return DW'(w);
    endfunction
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        wcnt_d      = wcnt_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        FIFO_READ   = '0;
        pop         = 1'b0;
        wcnt_n      = wcnt_q;

        req       = ~FIFO_EMPTY & CH_ENABLE;
        slot_free = ~out_valid_q | OUT_READY;
        burst_ok  = (BURST_LEN == 8'd0) || (wcnt_q < BURST_LEN);

        if (OUT_READY) out_valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|req) begin
                    grant_d = rr_pick(last_q, req);
`ifdef TOFPET_ARB_HEADER_EN
                    state_d = HDR;
`else
                    state_d = XFER;
`endif
                end
            end
`ifdef TOFPET_ARB_HEADER_EN
            HDR: begin
                if (slot_free) begin
                    out_data_d  = hdr_word(grant_q);
                    out_ch_d    = grant_q;
                    out_valid_d = 1'b1;
                    state_d     = XFER;
                end
            end
`endif
            XFER: begin
                pop = ~FIFO_EMPTY[grant_q] & CH_ENABLE[grant_q] & slot_free & burst_ok;
                FIFO_READ[grant_q] = pop;
                if (pop) begin
                    out_data_d  = FIFO_DATA[grant_q*DW +: DW];
                    out_ch_d    = grant_q;
                    out_valid_d = 1'b1;
                    wcnt_n      = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
                    wcnt_d      = wcnt_n;
                end
                // Exit uses the post-pop count, so a shrunk BURST_LEN also ends the burst.
                if (FIFO_EMPTY[grant_q] || !CH_ENABLE[grant_q] ||
                    ((BURST_LEN != 8'd0) && (wcnt_n >= BURST_LEN))) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    wcnt_d  = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            grant_q     <= 3'd0;
            last_q      <= 3'(NCH - 1);
            wcnt_q      <= 8'd0;
            out_data_q  <= '0;
            out_ch_q    <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            last_q      <= last_d;
            wcnt_q      <= wcnt_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_VALID = out_valid_q;
    assign BUSY      = (state_q != IDLE);
    assign GRANT_CH  = grant_q;

endmodule

// File: tb/tb_tofpet_readout_arbiter.sv
// Directed bench for tofpet_readout_arbiter: behavioural FIFOs feed the DUT, accepted words are logged.
module tb_tofpet_readout_arbiter;
    localparam int DW  = 32;
    localparam int NCH = 6;
`ifdef TOFPET_ARB_HEADER_EN
    localparam int BUB = 3;
`else
    localparam int BUB = 2;
`endif

    logic              CK;
    logic              RESET;
    logic [NCH*DW-1:0] FIFO_DATA;
    logic [NCH-1:0]    FIFO_EMPTY;
    logic [NCH-1:0]    FIFO_READ;
    logic [NCH-1:0]    CH_ENABLE;
    logic [7:0]        BURST_LEN;
    logic [DW-1:0]     OUT_DATA;
    logic [2:0]        OUT_CH;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic              BUSY;
    logic [2:0]        GRANT_CH;

    tofpet_readout_arbiter #(.DW(DW), .NCH(NCH)) dut (
        .CK(CK), .RESET(RESET), .FIFO_DATA(FIFO_DATA), .FIFO_EMPTY(FIFO_EMPTY),
        .FIFO_READ(FIFO_READ), .CH_ENABLE(CH_ENABLE), .BURST_LEN(BURST_LEN),
        .OUT_DATA(OUT_DATA), .OUT_CH(OUT_CH), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .BUSY(BUSY), .GRANT_CH(GRANT_CH)
    );

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] data;
        int          cyc;
    } ent_t;

    int   rd_ptr[NCH];
    int   wr_cnt[NCH];
    ent_t log_q[$];
    ent_t hdr_q[$];
    int   cyc;
    int   passed = 0;
    int   total  = 0;

    function automatic logic [31:0] word(input int ch, input int idx);
        return {8'hA0, 5'd0, 3'(ch), 16'(idx)};
    endfunction

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    always_comb begin
        FIFO_DATA  = '0;
        FIFO_EMPTY = '0;
        for (int i = 0; i < NCH; i++) begin
            FIFO_EMPTY[i]         = (rd_ptr[i] == wr_cnt[i]);
            FIFO_DATA[i*DW +: DW] = word(i, rd_ptr[i]);
        end
    end

    initial begin
        cyc = 0;
        for (int i = 0; i < NCH; i++) begin
            rd_ptr[i] = 0;
            wr_cnt[i] = 0;
        end
    end

    always @(posedge CK) begin
        ent_t e;
        cyc <= cyc + 1;
        for (int i = 0; i < NCH; i++)
            if (FIFO_READ[i]) rd_ptr[i] <= rd_ptr[i] + 1;
        if (OUT_VALID && OUT_READY) begin
            e.ch = OUT_CH; e.data = OUT_DATA; e.cyc = cyc;
            if (OUT_DATA[31:16] == 16'hC0DE) hdr_q.push_back(e);
            else log_q.push_back(e);
        end
    end

    task automatic wait_idle(input int maxc, output bit to);
        to = 1'b1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge CK);
            if (((FIFO_EMPTY | ~CH_ENABLE) == '1) && !BUSY && !OUT_VALID) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; OUT_READY = 1'b1; CH_ENABLE = '1; BURST_LEN = 8'd0;
        repeat (2) @(negedge CK);
        total++; if (OUT_VALID !== 1'b0) $display("FAIL reset_valid got=%b exp=0", OUT_VALID); else passed++;
        total++; if (OUT_DATA !== '0) $display("FAIL reset_data got=%h exp=0", OUT_DATA); else passed++;
        total++; if (OUT_CH !== 3'd0) $display("FAIL reset_ch got=%0d exp=0", OUT_CH); else passed++;
        total++; if (BUSY !== 1'b0) $display("FAIL reset_busy got=%b exp=0", BUSY); else passed++;
        total++; if (GRANT_CH !== 3'd0) $display("FAIL reset_grant got=%0d exp=0", GRANT_CH); else passed++;
        total++; if (FIFO_READ !== '0) $display("FAIL reset_read got=%b exp=0", FIFO_READ); else passed++;
        RESET = 1'b0;
        @(negedge CK);
    endtask

    task automatic test_single();
        int s, nread, first, lastc;
        bit to;
        log_q.delete(); BURST_LEN = 8'd0;
        s = rd_ptr[0]; wr_cnt[0] += 3;
        nread = 0; first = -1; lastc = -1; to = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CK);
            if (FIFO_READ[0]) begin
                nread++;
                if (first < 0) first = c;
                lastc = c;
            end
            if (FIFO_EMPTY[0] && !BUSY && !OUT_VALID) begin to = 1'b0; break; end
        end
        total++; if (to) $display("FAIL single_timeout got=timeout exp=idle"); else passed++;
        total++; if (nread != 3) $display("FAIL single_reads got=%0d exp=3", nread); else passed++;
        total++; if (lastc - first != 2) $display("FAIL single_read_run got=%0d exp=2", lastc - first); else passed++;
        total++; if (log_q.size() != 3) $display("FAIL single_count got=%0d exp=3", log_q.size()); else passed++;
        for (int k = 0; k < log_q.size() && k < 3; k++) begin
            total++;
            if (log_q[k].ch !== 3'd0 || log_q[k].data !== word(0, s + k))
                $display("FAIL single_word%0d got=%0d/%h exp=0/%h", k, log_q[k].ch, log_q[k].data, word(0, s + k));
            else passed++;
        end
        if (log_q.size() == 3) begin
            total++;
            if (log_q[2].cyc - log_q[0].cyc != 2) $display("FAIL single_back2back got=%0d exp=2", log_q[2].cyc - log_q[0].cyc);
            else passed++;
        end
    endtask

    task automatic test_burst();
        int pat_ch[6] = '{1, 4, 1, 4, 1, 4};
        int pat_n[6]  = '{4, 4, 4, 4, 2, 2};
        int nxt[NCH];
        int k, s1, s4;
        bit to;
        log_q.delete(); BURST_LEN = 8'd4;
        for (int i = 0; i < NCH; i++) nxt[i] = rd_ptr[i];
        s1 = rd_ptr[1]; s4 = rd_ptr[4];
        wr_cnt[1] += 10; wr_cnt[4] += 10;
        wait_idle(300, to);
        total++; if (to) $display("FAIL burst_timeout got=timeout exp=idle"); else passed++;
        total++; if (log_q.size() != 20) $display("FAIL burst_count got=%0d exp=20", log_q.size()); else passed++;
        k = 0;
        for (int p = 0; p < 6; p++) begin
            for (int j = 0; j < pat_n[p]; j++) begin
                if (k < log_q.size()) begin
                    total++;
                    if (log_q[k].ch !== 3'(pat_ch[p]) || log_q[k].data !== word(pat_ch[p], nxt[pat_ch[p]]))
                        $display("FAIL burst_word%0d got=%0d/%h exp=%0d/%h", k, log_q[k].ch, log_q[k].data,
                                 pat_ch[p], word(pat_ch[p], nxt[pat_ch[p]]));
                    else passed++;
                end
                nxt[pat_ch[p]]++;
                k++;
            end
        end
        total++; if (rd_ptr[1] != s1 + 10 || rd_ptr[4] != s4 + 10)
            $display("FAIL burst_pops got=%0d,%0d exp=10,10", rd_ptr[1] - s1, rd_ptr[4] - s4); else passed++;
    endtask

    task automatic test_stall();
        int s;
        logic [DW-1:0] held;
        bit to;
        log_q.delete(); BURST_LEN = 8'd0;
        s = rd_ptr[2]; wr_cnt[2] += 8;
        to = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CK);
            if (log_q.size() >= 2) begin to = 1'b0; break; end
        end
        total++; if (to) $display("FAIL stall_start got=timeout exp=2 words"); else passed++;
        OUT_READY = 1'b0;
        #1;
        held = OUT_DATA;
        total++; if (OUT_VALID !== 1'b1) $display("FAIL stall_valid got=%b exp=1", OUT_VALID); else passed++;
        repeat (5) begin
            total++;
            if (FIFO_READ !== '0 || OUT_DATA !== held)
                $display("FAIL stall_hold got=%b/%h exp=0/%h", FIFO_READ, OUT_DATA, held);
            else passed++;
            @(negedge CK);
        end
        OUT_READY = 1'b1;
        wait_idle(100, to);
        total++; if (to) $display("FAIL stall_timeout got=timeout exp=idle"); else passed++;
        total++; if (log_q.size() != 8) $display("FAIL stall_count got=%0d exp=8", log_q.size()); else passed++;
        for (int k = 0; k < log_q.size(); k++) begin
            total++;
            if (log_q[k].ch !== 3'd2 || log_q[k].data !== word(2, s + k))
                $display("FAIL stall_word%0d got=%0d/%h exp=2/%h", k, log_q[k].ch, log_q[k].data, word(2, s + k));
            else passed++;
        end
    endtask

    task automatic test_disable();
        int s, s0, popped;
        bit to, bad;
        log_q.delete(); BURST_LEN = 8'd0;
        s = rd_ptr[2]; wr_cnt[2] += 10;
        to = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CK);
            if (rd_ptr[2] - s >= 3) begin to = 1'b0; break; end
        end
        total++; if (to) $display("FAIL disable_start got=timeout exp=3 pops"); else passed++;
        CH_ENABLE[2] = 1'b0;
        s0 = rd_ptr[0]; wr_cnt[0] += 2;
        popped = rd_ptr[2];
        #1;
        total++; if (FIFO_READ[2] !== 1'b0) $display("FAIL disable_read_now got=%b exp=0", FIFO_READ[2]); else passed++;
        bad = 1'b0; to = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CK);
            if (FIFO_READ[2]) bad = 1'b1;
            if (((FIFO_EMPTY | ~CH_ENABLE) == '1) && !BUSY && !OUT_VALID) begin to = 1'b0; break; end
        end
        total++; if (to) $display("FAIL disable_timeout got=timeout exp=idle"); else passed++;
        total++; if (bad || rd_ptr[2] != popped) $display("FAIL disable_no_read got=%0d exp=%0d", rd_ptr[2], popped); else passed++;
        total++; if (rd_ptr[0] != s0 + 2) $display("FAIL disable_move_on got=%0d exp=2", rd_ptr[0] - s0); else passed++;
        total++; if (GRANT_CH !== 3'd0) $display("FAIL disable_grant got=%0d exp=0", GRANT_CH); else passed++;
        wr_cnt[2] = rd_ptr[2];
        CH_ENABLE = '1;
        @(negedge CK);
    endtask

    task automatic test_reset_mid();
        int s1, s3, p3;
        bit to;
        log_q.delete(); BURST_LEN = 8'd0;
        s3 = rd_ptr[3]; wr_cnt[3] += 10;
        to = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge CK);
            if (log_q.size() >= 3) begin to = 1'b0; break; end
        end
        total++; if (to) $display("FAIL rstmid_start got=timeout exp=3 words"); else passed++;
        s1 = rd_ptr[1]; wr_cnt[1] += 2;
        RESET = 1'b1;
        #1;
        total++; if (OUT_VALID !== 1'b0 || OUT_DATA !== '0) $display("FAIL rstmid_out got=%b/%h exp=0/0", OUT_VALID, OUT_DATA); else passed++;
        total++; if (FIFO_READ !== '0 || BUSY !== 1'b0) $display("FAIL rstmid_ctl got=%b/%b exp=0/0", FIFO_READ, BUSY); else passed++;
        p3 = rd_ptr[3];
        @(negedge CK);
        total++; if (rd_ptr[3] != p3) $display("FAIL rstmid_nopop got=%0d exp=%0d", rd_ptr[3], p3); else passed++;
        log_q.delete();
        RESET = 1'b0;
        wait_idle(100, to);
        total++; if (to) $display("FAIL rstmid_timeout got=timeout exp=idle"); else passed++;
        total++; if (log_q.size() == 0 || log_q[0].ch !== 3'd1)
            $display("FAIL rstmid_first got=%0d exp=1", (log_q.size() == 0) ? -1 : int'(log_q[0].ch)); else passed++;
        total++; if (log_q.size() != 2 + (s3 + 10 - p3))
            $display("FAIL rstmid_count got=%0d exp=%0d", log_q.size(), 2 + (s3 + 10 - p3)); else passed++;
        total++; if (rd_ptr[1] != s1 + 2) $display("FAIL rstmid_ch1 got=%0d exp=2", rd_ptr[1] - s1); else passed++;
    endtask

    task automatic test_back_to_back();
        int s;
        int gap_exp[4] = '{1, BUB, 1, BUB};
        bit to;
        log_q.delete(); BURST_LEN = 8'd2;
        s = rd_ptr[5]; wr_cnt[5] += 5;
        wait_idle(100, to);
        total++; if (to) $display("FAIL b2b_timeout got=timeout exp=idle"); else passed++;
        total++; if (log_q.size() != 5) $display("FAIL b2b_count got=%0d exp=5", log_q.size()); else passed++;
        for (int k = 0; k < log_q.size(); k++) begin
            total++;
            if (log_q[k].ch !== 3'd5 || log_q[k].data !== word(5, s + k))
                $display("FAIL b2b_word%0d got=%0d/%h exp=5/%h", k, log_q[k].ch, log_q[k].data, word(5, s + k));
            else passed++;
        end
        for (int k = 0; k < 4 && k + 1 < log_q.size(); k++) begin
            total++;
            if (log_q[k+1].cyc - log_q[k].cyc != gap_exp[k])
                $display("FAIL b2b_gap%0d got=%0d exp=%0d", k, log_q[k+1].cyc - log_q[k].cyc, gap_exp[k]);
            else passed++;
        end
        BURST_LEN = 8'd0;
    endtask

`ifdef TOFPET_ARB_HEADER_EN
    task automatic test_header();
        int s;
        bit to;
        log_q.delete(); hdr_q.delete(); BURST_LEN = 8'd0;
        s = rd_ptr[3]; wr_cnt[3] += 2;
        wait_idle(100, to);
        total++; if (to) $display("FAIL hdr_timeout got=timeout exp=idle"); else passed++;
        total++; if (hdr_q.size() != 1) $display("FAIL hdr_count got=%0d exp=1", hdr_q.size()); else passed++;
        if (hdr_q.size() > 0) begin
            total++;
            if (hdr_q[0].data !== 32'hC0DE0003 || hdr_q[0].ch !== 3'd3)
                $display("FAIL hdr_word got=%0d/%h exp=3/c0de0003", hdr_q[0].ch, hdr_q[0].data);
            else passed++;
        end
        total++; if (log_q.size() != 2) $display("FAIL hdr_data_count got=%0d exp=2", log_q.size()); else passed++;
        for (int k = 0; k < log_q.size(); k++) begin
            total++;
            if (log_q[k].ch !== 3'd3 || log_q[k].data !== word(3, s + k) || (hdr_q.size() > 0 && log_q[k].cyc <= hdr_q[0].cyc))
                $display("FAIL hdr_data%0d got=%0d/%h exp=3/%h", k, log_q[k].ch, log_q[k].data, word(3, s + k));
            else passed++;
        end
    endtask
`endif

    initial begin
        RESET = 1'b1; OUT_READY = 1'b1; CH_ENABLE = '1; BURST_LEN = 8'd0;
        test_reset();
        test_single();
        test_burst();
        test_stall();
        test_disable();
        test_reset_mid();
        test_back_to_back();
`ifdef TOFPET_ARB_HEADER_EN
        test_header();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
